// File: rtl/hls_dl_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock confirm unit.
package hls_dl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        REPORT  = 2'd2,
        HOLD    = 2'd3
    } dl_state_t;

    // Counter width able to hold values 0..n.
    function automatic int unsigned dl_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hls_dl_dep_merge.sv
// Valid-gated OR reduction of the incoming channel dependence vectors.
module hls_dl_dep_merge #(
    parameter int unsigned PROC_NUM    = 4,
    parameter int unsigned IN_CHAN_NUM = 2
) (
    input  logic [IN_CHAN_NUM-1:0]          vld_i,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] data_i,
    output logic [PROC_NUM-1:0]             merged_o
);

    always_comb begin
        merged_o = '0;
        for (int unsigned i = 0; i < IN_CHAN_NUM; i++) begin
            if (vld_i[i]) begin
                merged_o = merged_o | data_i[i*PROC_NUM +: PROC_NUM];
            end
        end
    end

endmodule

// File: rtl/hls_deadlock_confirm_unit.sv
// Per-process deadlock detector: reports a self-dependence loop only after it persists
// CONFIRM_CYCLES cycles. Define DL_DETECT_SNAPSHOT_EN to add the first-report snapshot ports.
module hls_deadlock_confirm_unit
    import hls_dl_pkg::*;
#(
    parameter int unsigned PROC_NUM       = 4,
    parameter int unsigned PROC_ID        = 0,
    parameter int unsigned IN_CHAN_NUM    = 2,
    parameter int unsigned OUT_CHAN_NUM   = 3,
    parameter int unsigned CONFIRM_CYCLES = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [1:0]                      dl_state
`ifdef DL_DETECT_SNAPSHOT_EN
    ,
    output logic [PROC_NUM-1:0]             dl_snap_dep,
    output logic [31:0]                     dl_snap_time,
    output logic                            dl_snap_vld
`endif
);

    localparam int unsigned          CNT_W    = dl_cnt_w(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_INIT = (CONFIRM_CYCLES == 1) ? CNT_W'(0) : CNT_W'(1);
    localparam logic [PROC_NUM-1:0]  SELF_BIT = PROC_NUM'(1) << PROC_ID;

    logic [PROC_NUM-1:0]     dep_merged;
    logic [PROC_NUM-1:0]     dep_live;
    logic                    gate_open;
    logic                    proc_blocked;
    logic                    hit;

    logic [PROC_NUM-1:0]     dep_q, dep_d;
    dl_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUT_CHAN_NUM-1:0] token_q, token_d;
    logic                    detect_q, detect_d;

    hls_dl_dep_merge #(
        .PROC_NUM    (PROC_NUM),
        .IN_CHAN_NUM (IN_CHAN_NUM)
    ) u_dep_merge (
        .vld_i    (in_chan_dep_vld_vec),
        .data_i   (in_chan_dep_data_vec),
        .merged_o (dep_merged)
    );

    // Once the region is flagged, only a token holder keeps tracking fresh dependences.
    always_comb begin
        gate_open    = ~dl_detect_in | (|token_in_vec);
        proc_blocked = |proc_dep_vld_vec;
        dep_live     = gate_open ? dep_merged : dep_q;
        hit          = gate_open & dep_live[PROC_ID] & proc_blocked;
        dep_d        = proc_blocked ? dep_live : '0;
        token_d      = (((|token_in_vec) & ~token_clear) | origin) ? proc_dep_vld_vec : '0;
    end

    // Confirmation FSM; a closed gate freezes progress instead of aborting it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = (CONFIRM_CYCLES == 1) ? REPORT : CONFIRM;
                    cnt_d   = CNT_INIT;
                end
            end
            CONFIRM: begin
                if (gate_open) begin
                    if (hit) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = REPORT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            REPORT: begin
                state_d = hit ? HOLD : IDLE;
                cnt_d   = '0;
            end
            HOLD: begin
                if (~hit & gate_open) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        detect_d = (state_d == REPORT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dep_q    <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            token_q  <= '0;
            detect_q <= 1'b0;
        end else begin
            dep_q    <= dep_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            token_q  <= token_d;
            detect_q <= detect_d;
        end
    end

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_q | SELF_BIT;
    assign token_out_vec        = token_q;
    assign dl_detect_out        = detect_q;
    assign dl_state             = state_q;

`ifdef DL_DETECT_SNAPSHOT_EN
    logic [31:0]         cyc_q;
    logic [PROC_NUM-1:0] snap_dep_q;
    logic [31:0]         snap_time_q;
    logic                snap_vld_q;

    // Free-running timestamp; only the first report of a reset epoch is captured.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_q       <= '0;
            snap_dep_q  <= '0;
            snap_time_q <= '0;
            snap_vld_q  <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (detect_d && !snap_vld_q) begin
                snap_dep_q  <= dep_live;
                snap_time_q <= cyc_q;
                snap_vld_q  <= 1'b1;
            end
        end
    end

    assign dl_snap_dep  = snap_dep_q;
    assign dl_snap_time = snap_time_q;
    assign dl_snap_vld  = snap_vld_q;
`endif

endmodule

// File: tb/tb_hls_deadlock_confirm_unit.sv
// Directed self-checking bench for hls_deadlock_confirm_unit (PROC_NUM=4, PROC_ID=0, CONFIRM_CYCLES=4).
module tb_hls_deadlock_confirm_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] proc_dep_vld_vec;
    logic [1:0] in_chan_dep_vld_vec;
    logic [7:0] in_chan_dep_data_vec;
    logic [1:0] token_in_vec;
    logic       dl_detect_in;
    logic       origin;
    logic       token_clear;
    logic [2:0] out_chan_dep_vld_vec;
    logic [3:0] out_chan_dep_data;
    logic [2:0] token_out_vec;
    logic       dl_detect_out;
    logic [1:0] dl_state;

    int checks   = 0;
    int failures = 0;

    hls_deadlock_confirm_unit #(
        .PROC_NUM       (4),
        .PROC_ID        (0),
        .IN_CHAN_NUM    (2),
        .OUT_CHAN_NUM   (3),
        .CONFIRM_CYCLES (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .proc_dep_vld_vec     (proc_dep_vld_vec),
        .in_chan_dep_vld_vec  (in_chan_dep_vld_vec),
        .in_chan_dep_data_vec (in_chan_dep_data_vec),
        .token_in_vec         (token_in_vec),
        .dl_detect_in         (dl_detect_in),
        .origin               (origin),
        .token_clear          (token_clear),
        .out_chan_dep_vld_vec (out_chan_dep_vld_vec),
        .out_chan_dep_data    (out_chan_dep_data),
        .token_out_vec        (token_out_vec),
        .dl_detect_out        (dl_detect_out),
        .dl_state             (dl_state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        proc_dep_vld_vec     = '0;
        in_chan_dep_vld_vec  = '0;
        in_chan_dep_data_vec = '0;
        token_in_vec         = '0;
        dl_detect_in         = 1'b0;
        origin               = 1'b0;
        token_clear          = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic set_hit();
        proc_dep_vld_vec     = 3'b001;
        in_chan_dep_vld_vec  = 2'b01;
        in_chan_dep_data_vec = 8'h01;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            proc_dep_vld_vec     = 3'($urandom);
            in_chan_dep_vld_vec  = 2'($urandom);
            in_chan_dep_data_vec = 8'($urandom);
            token_in_vec         = 2'($urandom);
            dl_detect_in         = 1'($urandom);
            origin               = 1'($urandom);
            token_clear          = 1'($urandom);
            step();
            checks++;
            if (token_out_vec !== 3'b000) begin
                failures++;
                $display("FAIL reset_token got=%b exp=000", token_out_vec);
            end
            checks++;
            if (dl_detect_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_detect got=%b exp=0", dl_detect_out);
            end
            checks++;
            if (dl_state !== 2'd0) begin
                failures++;
                $display("FAIL reset_state got=%0d exp=0", dl_state);
            end
            checks++;
            if (out_chan_dep_data !== 4'b0001) begin
                failures++;
                $display("FAIL reset_dep_data got=%b exp=0001", out_chan_dep_data);
            end
        end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_confirm();
        logic [1:0] exp_state;
        do_reset();
        set_hit();
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_state = (c < 4) ? 2'd1 : ((c == 4) ? 2'd2 : 2'd3);
            checks++;
            if (dl_detect_out !== (c == 4)) begin
                failures++;
                $display("FAIL confirm_pulse cyc=%0d got=%b exp=%b", c, dl_detect_out, (c == 4));
            end
            checks++;
            if (dl_state !== exp_state) begin
                failures++;
                $display("FAIL confirm_state cyc=%0d got=%0d exp=%0d", c, dl_state, exp_state);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        set_hit();
        for (int c = 1; c <= 3; c++) begin
            step();
        end
        proc_dep_vld_vec = 3'b000;
        step();
        checks++;
        if (dl_detect_out !== 1'b0 || dl_state !== 2'd0) begin
            failures++;
            $display("FAIL glitch_abort got det=%b st=%0d exp det=0 st=0", dl_detect_out, dl_state);
        end
        set_hit();
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (dl_detect_out !== (c == 4)) begin
                failures++;
                $display("FAIL glitch_restart cyc=%0d got=%b exp=%b", c, dl_detect_out, (c == 4));
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        proc_dep_vld_vec     = 3'b001;
        in_chan_dep_vld_vec  = 2'b01;
        in_chan_dep_data_vec = 8'h03;
        step();
        step();
        dl_detect_in         = 1'b1;
        token_in_vec         = 2'b00;
        in_chan_dep_data_vec = 8'h09;
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (dl_state !== 2'd1 || dl_detect_out !== 1'b0) begin
                failures++;
                $display("FAIL freeze_hold cyc=%0d got st=%0d det=%b exp st=1 det=0", c, dl_state, dl_detect_out);
            end
        end
        checks++;
        if (out_chan_dep_data !== 4'b0011) begin
            failures++;
            $display("FAIL freeze_dep_reg got=%b exp=0011", out_chan_dep_data);
        end
        token_in_vec         = 2'b01;
        in_chan_dep_data_vec = 8'h03;
        step();
        checks++;
        if (dl_detect_out !== 1'b0 || dl_state !== 2'd1) begin
            failures++;
            $display("FAIL freeze_reopen1 got det=%b st=%0d exp det=0 st=1", dl_detect_out, dl_state);
        end
        step();
        checks++;
        if (dl_detect_out !== 1'b1 || dl_state !== 2'd2) begin
            failures++;
            $display("FAIL freeze_reopen2 got det=%b st=%0d exp det=1 st=2", dl_detect_out, dl_state);
        end
    endtask

    task automatic test_tokens();
        do_reset();
        proc_dep_vld_vec = 3'b101;
        origin           = 1'b1;
        #1;
        checks++;
        if (out_chan_dep_vld_vec !== 3'b101) begin
            failures++;
            $display("FAIL tok_vld_passthru got=%b exp=101", out_chan_dep_vld_vec);
        end
        step();
        checks++;
        if (token_out_vec !== 3'b101) begin
            failures++;
            $display("FAIL tok_origin got=%b exp=101", token_out_vec);
        end
        origin       = 1'b0;
        token_in_vec = 2'b10;
        token_clear  = 1'b1;
        step();
        checks++;
        if (token_out_vec !== 3'b000) begin
            failures++;
            $display("FAIL tok_clear got=%b exp=000", token_out_vec);
        end
        token_clear = 1'b0;
        step();
        checks++;
        if (token_out_vec !== 3'b101) begin
            failures++;
            $display("FAIL tok_forward got=%b exp=101", token_out_vec);
        end
        token_in_vec = 2'b00;
        origin       = 1'b1;
        token_clear  = 1'b1;
        step();
        checks++;
        if (token_out_vec !== 3'b101) begin
            failures++;
            $display("FAIL tok_origin_wins got=%b exp=101", token_out_vec);
        end
        proc_dep_vld_vec = 3'b000;
        step();
        checks++;
        if (token_out_vec !== 3'b000) begin
            failures++;
            $display("FAIL tok_no_block got=%b exp=000", token_out_vec);
        end
    endtask

    task automatic test_merge();
        do_reset();
        proc_dep_vld_vec     = 3'b010;
        in_chan_dep_vld_vec  = 2'b10;
        in_chan_dep_data_vec = {4'b0110, 4'b0001};
        step();
        checks++;
        if (out_chan_dep_data !== 4'b0111 || dl_state !== 2'd0) begin
            failures++;
            $display("FAIL merge_ch1 got dep=%b st=%0d exp dep=0111 st=0", out_chan_dep_data, dl_state);
        end
        in_chan_dep_vld_vec = 2'b11;
        in_chan_dep_data_vec = {4'b0110, 4'b1001};
        step();
        checks++;
        if (out_chan_dep_data !== 4'b1111 || dl_state !== 2'd1) begin
            failures++;
            $display("FAIL merge_both got dep=%b st=%0d exp dep=1111 st=1", out_chan_dep_data, dl_state);
        end
        proc_dep_vld_vec = 3'b000;
        step();
        checks++;
        if (out_chan_dep_data !== 4'b0001 || dl_state !== 2'd0) begin
            failures++;
            $display("FAIL merge_unblock got dep=%b st=%0d exp dep=0001 st=0", out_chan_dep_data, dl_state);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_hit();
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (dl_state !== 2'd0 || dl_detect_out !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state got st=%0d det=%b exp st=0 det=0", dl_state, dl_detect_out);
        end
        reset = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (dl_detect_out !== (c == 4)) begin
                failures++;
                $display("FAIL midreset_pulse cyc=%0d got=%b exp=%b", c, dl_detect_out, (c == 4));
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_confirm();
        test_glitch();
        test_freeze();
        test_tokens();
        test_merge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
